// File: rtl/paddle_motion_controller.sv
// Multi-paddle vertical motion controller.
// Each paddle moves on a divided movement tick. Positions saturate at the
// playfield bounds, and a held direction accelerates from a slow step to a
// fast step after HOLD_TICKS consecutive same-direction ticks.
module paddle_motion_controller #(
   parameter int NUM_PADDLES = 2,
   parameter int POS_W       = 16,
   parameter int POS_MIN     = 160,
   parameter int POS_MAX     = 400,
   parameter int POS_INIT    = 300,
   parameter int STEP        = 10,
   parameter int FAST_MULT   = 3,
   parameter int HOLD_TICKS  = 4,
   parameter int TICK_DIV    = 833334
) (
   input  logic                         clk,
   input  logic                         reset_to_start_n,
   input  logic                         stand,
   input  logic [NUM_PADDLES-1:0]       move_up,
   input  logic [NUM_PADDLES-1:0]       move_down,
   output logic [NUM_PADDLES*POS_W-1:0] paddle_pos,
   output logic [NUM_PADDLES-1:0]       at_top,
   output logic [NUM_PADDLES-1:0]       at_bottom
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HC_W  = $clog2(HOLD_TICKS + 1);
   localparam int XW    = POS_W + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [HC_W-1:0]  HOLD_SAT = HC_W'(HOLD_TICKS);
   localparam logic [XW-1:0]    MIN_X    = XW'(POS_MIN);
   localparam logic [XW-1:0]    MAX_X    = XW'(POS_MAX);
   localparam logic [XW-1:0]    SLOW_X   = XW'(STEP);
   localparam logic [XW-1:0]    FAST_X   = XW'(STEP * FAST_MULT);
   localparam logic [POS_W-1:0] MIN_P    = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0] MAX_P    = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0] INIT_P   = POS_W'(POS_INIT);

   typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

   logic [CNT_W-1:0] cnt_q;
   logic             tick;

   state_t           state_q [NUM_PADDLES];
   state_t           state_d [NUM_PADDLES];
   logic             dir_q   [NUM_PADDLES];   // 1 = up, 0 = down
   logic             dir_d   [NUM_PADDLES];
   logic [HC_W-1:0]  hold_q  [NUM_PADDLES];
   logic [HC_W-1:0]  hold_d  [NUM_PADDLES];
   logic [POS_W-1:0] pos_q   [NUM_PADDLES];
   logic [POS_W-1:0] pos_d   [NUM_PADDLES];
   logic             req_vld [NUM_PADDLES];
   logic             same_dir[NUM_PADDLES];
   logic [XW-1:0]    step_x  [NUM_PADDLES];
   logic [XW-1:0]    pos_x   [NUM_PADDLES];

   assign tick = (cnt_q == CNT_LAST);

   // Per-paddle next position / state, applied only on a tick; the step size
   // is chosen from the pre-tick state so a reversal out of FAST moves fast.
   always_comb begin
      for (int i = 0; i < NUM_PADDLES; i++) begin
         req_vld[i]  = move_up[i] ^ move_down[i];
         same_dir[i] = req_vld[i] && (state_q[i] != IDLE) && (dir_q[i] == move_up[i]);
         step_x[i]   = (state_q[i] == FAST) ? FAST_X : SLOW_X;
         pos_x[i]    = {1'b0, pos_q[i]};
         pos_d[i]    = pos_q[i];
         state_d[i]  = IDLE;
         hold_d[i]   = '0;
         dir_d[i]    = dir_q[i];
         if (req_vld[i]) begin
            // Extra headroom bit keeps the bound comparisons free of wrap-around.
            if (move_up[i]) begin
               if ((pos_x[i] < step_x[i]) || ((pos_x[i] - step_x[i]) <= MIN_X))
                  pos_d[i] = MIN_P;
               else
                  pos_d[i] = POS_W'(pos_x[i] - step_x[i]);
            end else begin
               if ((pos_x[i] + step_x[i]) >= MAX_X)
                  pos_d[i] = MAX_P;
               else
                  pos_d[i] = POS_W'(pos_x[i] + step_x[i]);
            end
            if (same_dir[i]) begin
               hold_d[i]  = (hold_q[i] == HOLD_SAT) ? hold_q[i] : hold_q[i] + HC_W'(1);
               state_d[i] = (hold_d[i] == HOLD_SAT) ? FAST : SLOW;
            end else begin
               hold_d[i]  = HC_W'(1);
               state_d[i] = SLOW;
               dir_d[i]   = move_up[i];
            end
         end
      end
   end

   // Tick divider and per-paddle registers; reset beats stand, stand beats tick.
   always_ff @(posedge clk) begin
      if (!reset_to_start_n) begin
         cnt_q <= '0;
         for (int i = 0; i < NUM_PADDLES; i++) begin
            pos_q[i]   <= INIT_P;
            state_q[i] <= IDLE;
            hold_q[i]  <= '0;
            dir_q[i]   <= 1'b1;
         end
      end else if (stand) begin
         cnt_q <= '0;
         for (int i = 0; i < NUM_PADDLES; i++) begin
            state_q[i] <= IDLE;
            hold_q[i]  <= '0;
         end
      end else begin
         cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
         if (tick) begin
            for (int i = 0; i < NUM_PADDLES; i++) begin
               pos_q[i]   <= pos_d[i];
               state_q[i] <= state_d[i];
               hold_q[i]  <= hold_d[i];
               dir_q[i]   <= dir_d[i];
            end
         end
      end
   end

   // Pack positions onto the output bus and flag the bounds.
   always_comb begin
      paddle_pos = '0;
      at_top     = '0;
      at_bottom  = '0;
      for (int i = 0; i < NUM_PADDLES; i++) begin
         paddle_pos[i*POS_W +: POS_W] = pos_q[i];
         at_top[i]    = (pos_q[i] == MIN_P);
         at_bottom[i] = (pos_q[i] == MAX_P);
      end
   end

endmodule

// File: tb/tb_paddle_motion_controller.sv
// Directed testbench for paddle_motion_controller: a two-paddle instance with
// a short tick divider and a four-paddle instance ticking every cycle.
module tb_paddle_motion_controller;

   logic        clk;
   logic        rst_n;
   logic        stand;
   logic [1:0]  up;
   logic [1:0]  dn;
   logic [31:0] pos;
   logic [1:0]  top;
   logic [1:0]  bot;

   logic        rst2_n;
   logic        stand2;
   logic [3:0]  up2;
   logic [3:0]  dn2;
   logic [63:0] pos2;
   logic [3:0]  top2;
   logic [3:0]  bot2;

   int checks;
   int failures;

   typedef struct {
      logic [1:0]  up;
      logic [1:0]  dn;
      logic [15:0] p0;
      logic [15:0] p1;
      logic [1:0]  top;
      logic [1:0]  bot;
   } vec_t;

   vec_t vecs [28];

   paddle_motion_controller #(.TICK_DIV(4)) dut (
      .clk              (clk),
      .reset_to_start_n (rst_n),
      .stand            (stand),
      .move_up          (up),
      .move_down        (dn),
      .paddle_pos       (pos),
      .at_top           (top),
      .at_bottom        (bot)
   );

   paddle_motion_controller #(
      .NUM_PADDLES (4),
      .TICK_DIV    (1),
      .STEP        (7),
      .POS_MIN     (0),
      .POS_MAX     (20),
      .POS_INIT    (3)
   ) dut2 (
      .clk              (clk),
      .reset_to_start_n (rst2_n),
      .stand            (stand2),
      .move_up          (up2),
      .move_down        (dn2),
      .paddle_pos       (pos2),
      .at_top           (top2),
      .at_bottom        (bot2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [15:0] p0, input logic [15:0] p1,
                            input logic [1:0] t, input logic [1:0] b);
      check({name, "_pos0"}, 64'(pos[15:0]), 64'(p0));
      check({name, "_pos1"}, 64'(pos[31:16]), 64'(p1));
      check({name, "_top"}, 64'(top), 64'(t));
      check({name, "_bot"}, 64'(bot), 64'(b));
   endtask

   // One movement tick of the TICK_DIV=4 instance, sampled just after the update edge.
   task automatic one_tick();
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n  = 1'b0; stand  = 1'b0; up  = '0; dn  = '0;
      rst2_n = 1'b0; stand2 = 1'b0; up2 = '0; dn2 = '0;

      vecs[0]  = '{2'b01, 2'b00, 16'd280, 16'd300, 2'b00, 2'b00};
      vecs[1]  = '{2'b01, 2'b00, 16'd270, 16'd300, 2'b00, 2'b00};
      vecs[2]  = '{2'b01, 2'b00, 16'd260, 16'd300, 2'b00, 2'b00};
      vecs[3]  = '{2'b01, 2'b00, 16'd230, 16'd300, 2'b00, 2'b00};
      vecs[4]  = '{2'b01, 2'b00, 16'd200, 16'd300, 2'b00, 2'b00};
      vecs[5]  = '{2'b01, 2'b00, 16'd170, 16'd300, 2'b00, 2'b00};
      vecs[6]  = '{2'b01, 2'b00, 16'd160, 16'd300, 2'b01, 2'b00};
      vecs[7]  = '{2'b01, 2'b00, 16'd160, 16'd300, 2'b01, 2'b00};
      vecs[8]  = '{2'b00, 2'b10, 16'd160, 16'd310, 2'b01, 2'b00};
      vecs[9]  = '{2'b00, 2'b10, 16'd160, 16'd320, 2'b01, 2'b00};
      vecs[10] = '{2'b00, 2'b10, 16'd160, 16'd330, 2'b01, 2'b00};
      vecs[11] = '{2'b00, 2'b10, 16'd160, 16'd340, 2'b01, 2'b00};
      vecs[12] = '{2'b00, 2'b10, 16'd160, 16'd370, 2'b01, 2'b00};
      vecs[13] = '{2'b00, 2'b10, 16'd160, 16'd400, 2'b01, 2'b10};
      vecs[14] = '{2'b00, 2'b10, 16'd160, 16'd400, 2'b01, 2'b10};
      vecs[15] = '{2'b00, 2'b11, 16'd170, 16'd400, 2'b00, 2'b10};
      vecs[16] = '{2'b00, 2'b11, 16'd180, 16'd400, 2'b00, 2'b10};
      vecs[17] = '{2'b00, 2'b11, 16'd190, 16'd400, 2'b00, 2'b10};
      vecs[18] = '{2'b00, 2'b11, 16'd200, 16'd400, 2'b00, 2'b10};
      vecs[19] = '{2'b00, 2'b11, 16'd230, 16'd400, 2'b00, 2'b10};
      vecs[20] = '{2'b01, 2'b10, 16'd200, 16'd400, 2'b00, 2'b10};
      vecs[21] = '{2'b01, 2'b10, 16'd190, 16'd400, 2'b00, 2'b10};
      vecs[22] = '{2'b01, 2'b11, 16'd190, 16'd400, 2'b00, 2'b10};
      vecs[23] = '{2'b00, 2'b11, 16'd200, 16'd400, 2'b00, 2'b10};
      vecs[24] = '{2'b00, 2'b11, 16'd210, 16'd400, 2'b00, 2'b10};
      vecs[25] = '{2'b00, 2'b11, 16'd220, 16'd400, 2'b00, 2'b10};
      vecs[26] = '{2'b00, 2'b11, 16'd230, 16'd400, 2'b00, 2'b10};
      vecs[27] = '{2'b00, 2'b11, 16'd260, 16'd400, 2'b00, 2'b10};

      // Reset for two cycles, then release with paddle 0 requesting up.
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 16'd300, 16'd300, 2'b00, 2'b00);
      rst_n = 1'b1;
      up    = 2'b01;
      repeat (3) @(posedge clk);
      #1;
      check("no_early_tick", 64'(pos[15:0]), 64'd300);
      @(posedge clk);
      #1;
      check_all("first_tick", 16'd290, 16'd300, 2'b00, 2'b00);

      // Table: acceleration, saturation, down bound, reversal, conflict.
      for (int i = 0; i < 28; i++) begin
         up = vecs[i].up;
         dn = vecs[i].dn;
         one_tick();
         check_all($sformatf("vec%0d", i), vecs[i].p0, vecs[i].p1, vecs[i].top, vecs[i].bot);
      end

      // Freeze while paddle 0 is fast at 260 with down held.
      stand = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check_all("stand_frozen", 16'd260, 16'd400, 2'b00, 2'b10);
      stand = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("stand_release_early", 64'(pos[15:0]), 64'd260);
      @(posedge clk);
      #1;
      check("stand_release_slow", 64'(pos[15:0]), 64'd270);

      // Reset mid-hold, together with stand, restores the start positions.
      stand = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_all("reset_mid", 16'd300, 16'd300, 2'b00, 2'b00);
      rst_n = 1'b1;
      stand = 1'b0;
      dn    = 2'b00;
      up    = 2'b00;

      // Four-paddle instance, tick every cycle, step 7 in [0,20].
      check("p4_reset_pos", pos2, {16'd3, 16'd3, 16'd3, 16'd3});
      check("p4_reset_top", 64'(top2), 64'd0);
      rst2_n = 1'b1;
      up2    = 4'b0100;
      @(posedge clk);
      #1;
      check("p4_up_clamp", pos2, {16'd3, 16'd0, 16'd3, 16'd3});
      check("p4_up_top", 64'(top2), 64'b0100);
      @(posedge clk);
      #1;
      check("p4_up_hold", pos2, {16'd3, 16'd0, 16'd3, 16'd3});
      dn2 = 4'b1000;
      @(posedge clk);
      #1;
      check("p4_dn1", pos2, {16'd10, 16'd0, 16'd3, 16'd3});
      @(posedge clk);
      #1;
      check("p4_dn2", pos2, {16'd17, 16'd0, 16'd3, 16'd3});
      check("p4_dn2_bot", 64'(bot2), 64'b0000);
      @(posedge clk);
      #1;
      check("p4_dn3", pos2, {16'd20, 16'd0, 16'd3, 16'd3});
      check("p4_dn3_bot", 64'(bot2), 64'b1000);
      check("p4_dn3_top", 64'(top2), 64'b0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/paddle_motion_controller.md
# paddle_motion_controller

Parametrised, multi-paddle successor to the game's paddle movement logic. Holds one vertical position register per paddle and moves each paddle on a divided movement tick from decoded up/down requests. Positions saturate at the playfield bounds instead of stopping short of them, and a held direction accelerates from a slow step to a fast step. Sits between the PS/2 key decoder and the VGA renderer / ball-collision logic.

## Interface
- NUM_PADDLES, 2, number of independent paddles (≥1)
- POS_W, 16, position width in bits
- POS_MIN, 160, top bound (smallest position)
- POS_MAX, 400, bottom bound (largest position)
- POS_INIT, 300, reset position; POS_MIN ≤ POS_INIT ≤ POS_MAX
- STEP, 10, slow step in pixels
- FAST_MULT, 3, fast step = STEP*FAST_MULT
- HOLD_TICKS, 4, consecutive same-direction ticks before fast mode (≥1)
- TICK_DIV, 833334, clk cycles per movement tick (≥1; 1 = every cycle)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_to_start_n  in  1  synchronous, active-low reset
- stand  in  1  freeze: no movement while high
- move_up  in  NUM_PADDLES  bit i: paddle i up request (level)
- move_down  in  NUM_PADDLES  bit i: paddle i down request (level)
- paddle_pos  out  NUM_PADDLES*POS_W  paddle i at bits [i*POS_W +: POS_W], registered
- at_top  out  NUM_PADDLES  bit i = (pos_i == POS_MIN)
- at_bottom  out  NUM_PADDLES  bit i = (pos_i == POS_MAX)

## Operation
- Tick counter: counts 0..TICK_DIV-1 and wraps. Tick is asserted on the cycle the count equals TICK_DIV-1. The counter is held at 0 while stand=1.
- Per-paddle state: IDLE, SLOW, FAST. Each paddle also has a direction register dir (UP/DOWN) and hold_cnt (saturates at HOLD_TICKS).
- Request decode per paddle on a tick:
  - Valid request: exactly one of move_up[i] and move_down[i] is high.
  - No request, or both high: position unchanged, state → IDLE, hold_cnt → 0.
- Valid request on a tick:
  - Step size comes from the state before the tick: STEP in IDLE or SLOW, STEP*FAST_MULT in FAST.
  - Same dir as the stored dir and state ≠ IDLE: hold_cnt+1 (saturating). The state becomes FAST when the new hold_cnt == HOLD_TICKS.
  - Otherwise (from IDLE, or a direction reversal): state → SLOW, hold_cnt → 1, dir updated. The step is still taken from the pre-tick state, so a reversal out of FAST moves one fast step in the new direction.
- Arithmetic is done in POS_W+1 bits, so no wrap-around can occur.
  - UP: new = max(pos − step, POS_MIN).
  - DOWN: new = min(pos + step, POS_MAX).
- Request against a bound (at POS_MIN going up, or at POS_MAX going down): position unchanged, but state/hold_cnt still advance.
- Paddles are fully independent. Simultaneous requests on different paddles all apply on the same tick.
- Outside ticks, positions, states and counters hold.
- stand=1: positions hold, all states → IDLE, all hold_cnt → 0, tick counter → 0.
- Reset (reset_to_start_n=0 on a rising edge) has priority over stand and tick:
  - all positions → POS_INIT, states → IDLE, hold_cnt → 0, tick counter → 0.
  - Reset outputs: paddle_pos = POS_INIT for every paddle; at_top/at_bottom per the POS_INIT comparison (0 with defaults).

## Timing
- Inputs are sampled only on the tick cycle. paddle_pos updates on the clk edge that ends the tick cycle, giving 1-cycle latency from the tick.
- at_top/at_bottom are combinational from the position registers and valid in the same cycle as paddle_pos.
- First tick after reset or stand release: TICK_DIV cycles after the release edge (count restarts at 0).
- Pulses shorter than the tick spacing that are not high on the tick cycle are ignored by design.
- Reset asserted mid-hold or mid-tick: takes effect on that edge. No partial update.

## Test plan
- Reset: hold reset_to_start_n=0 for 2 cycles, then release → both paddle_pos = 300, at_top = at_bottom = 00. The first tick falls TICK_DIV cycles after release (use TICK_DIV=4).
- Accelerate and saturate: move_up[0] held from 300 → pos0 after ticks 1-8 = 290, 280, 270, 260, 230, 200, 170, 160. It stays at 160 on further ticks with at_top[0]=1; pos1 stays at 300.
- Down bound: paddle 1 held down from 300 → 310, 320, 330, 340, 370, 400, 400; at_bottom[1]=1 from the 400 value.
- Reversal / conflict: paddle 0 in FAST at 230, switch to down → 260 (fast step from pre-tick state), then 270 (SLOW). Both up+down high → no move, state IDLE.
- stand: assert stand while paddle 0 is FAST at 200 with up held → position frozen for 10 ticks' worth of cycles. After release, the next move is 190 (slow), one TICK_DIV after release.
- Parameter sweep: NUM_PADDLES=4, TICK_DIV=1, STEP=7, POS_MIN=0, POS_MAX=20, POS_INIT=3 → up on paddle 2 gives 0 on the first cycle with no underflow wrap. The other paddles hold at 3.
